mfp_uart_receiver: RTL and testbench

UART byte receiver that sits directly upstream of the UART loader in the programmer path. It takes the raw asynchronous `uart_rx` pin and delivers validated 8-bit bytes as single-cycle strobes. The loader consumes these bytes and turns them into AHB writes. Format is 8N1, or 8E1 when parity is compiled in; LSB first; 1 stop bit.

---
 rtl/mfp_uart_receiver_pkg.sv | 21 ++
 rtl/mfp_uart_rx_sync.sv | 25 ++
 rtl/mfp_uart_receiver.sv | 157 +++++++++++++++
 tb/tb_mfp_uart_receiver.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_receiver_pkg.sv
// Shared UART definitions: FSM state encodings and bit-timing helpers.
// The helpers are meant to be reused by a future UART transmitter.
package mfp_uart_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_half_bit(input int clk_freq, input int baud);
    return calc_clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/mfp_uart_rx_sync.sv
// Two-flop synchronizer for the raw uart_rx pin.
// Both flops reset to 1 so an idle line never looks like a start edge.
module mfp_uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mfp_uart_receiver.sv
// 8N1 UART byte receiver; define MFP_UART_RX_PARITY_EN for 8E1 with even-parity
// checking. Delivers each good byte as a one-cycle byte_valid strobe.
module mfp_uart_receiver
  import mfp_uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BOUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BOUD_RATE);
  localparam int HALF_BIT     = calc_half_bit(CLK_FREQ, BOUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("mfp_uart_receiver: CLK_FREQ/BOUD_RATE must be at least 4");
  end

  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_data_q;
  logic             byte_valid_q;
  logic             frame_err_q;
  logic             rx_s;
  logic             rx_d_q;
`ifdef MFP_UART_RX_PARITY_EN
  logic             parity_err_q;
  logic             par_bad_q;
`endif

  mfp_uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (uart_rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d_q <= 1'b1;
    end else begin
      rx_d_q <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
      par_bad_q    <= 1'b0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        // Only a real 1->0 edge starts a frame, so a held break cannot retrigger.
        ST_IDLE: begin
          if (rx_d_q && !rx_s) begin
            cnt_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q             <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == 3'd7) begin
`ifdef MFP_UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_PARITY: begin
`ifdef MFP_UART_RX_PARITY_EN
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            par_bad_q <= (^shift_q) ^ rx_s;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`else
          state_q <= ST_IDLE;
`endif
        end
        ST_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
`ifdef MFP_UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
`endif
            end else begin
              byte_data_q  <= shift_q;
              byte_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != ST_IDLE);
`ifdef MFP_UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mfp_uart_receiver.sv
// Scoreboard bench for mfp_uart_receiver at 8 clocks per bit.
// Each driven frame queues its expected strobe; the monitor pops and compares.
module tb_mfp_uart_receiver;

  localparam int CPB  = 8;
  localparam int HALF = 4;
`ifdef MFP_UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Clock index (edge of the line fall = 0) at which the strobe is presented.
  localparam int STROBE_CLK = 4 + HALF + 9 * CPB + PBITS * CPB;

  localparam int K_VALID  = 0;
  localparam int K_FRAME  = 1;
  localparam int K_PARITY = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  mfp_uart_receiver #(
    .CLK_FREQ  (921600),
    .BOUD_RATE (115200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         clk_at;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [2:0] st;
    exp_t       e;
    st = {parity_err, frame_err, byte_valid};
    if (rst_n && st != 3'b000) begin
      check("strobe_onehot", $countones(st), 1);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, st}, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {29'd0, st}, 32'd1 << e.kind);
        check("byte_data", {24'd0, byte_data}, {24'd0, e.data});
        check("strobe_clock", cyc + 1, e.clk_at);
      end
    end
  end

  // Called 1 time unit after a rising edge; that edge is clock 0 of the frame.
  // The line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input int kind);
    exp_t e;
    e.kind   = kind;
    e.data   = (kind == K_VALID) ? d : last_good;
    e.clk_at = cyc + STROBE_CLK;
    sb.push_back(e);
    if (kind == K_VALID) last_good = d;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
`ifdef MFP_UART_RX_PARITY_EN
    uart_rx = par_bit;
    repeat (CPB) @(posedge clk);
    #1;
`endif
    uart_rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int         n;
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_data", {24'd0, byte_data}, 0);
    check("rst_byte_valid", {31'd0, byte_valid}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_parity_err", {31'd0, parity_err}, 0);
    check("rst_rx_busy", {31'd0, rx_busy}, 0);
    rst_n = 1'b1;
    idle(4);

    send_frame(8'hA5, ^8'hA5, 1'b1, K_VALID);
    idle(10);
    drain("drain_a5");

    send_frame(8'h00, 1'b0, 1'b1, K_VALID);
    send_frame(8'hFF, 1'b0, 1'b1, K_VALID);
    send_frame(8'h3C, 1'b0, 1'b1, K_VALID);
    idle(10);
    drain("drain_b2b");

    // 2-clock glitch: START is entered, then the half-bit sample sees high.
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy", {31'd0, rx_busy}, 1);
    n = 0;
    while (rx_busy && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("glitch_idle", {31'd0, rx_busy}, 0);
    idle(10);

    send_frame(8'h55, 1'b0, 1'b0, K_FRAME);
    repeat (40) @(posedge clk);
    #1;
    check("break_no_retrigger", {31'd0, rx_busy}, 0);
    idle(10);
    drain("drain_frame_err");
    check("held_byte_data", {24'd0, byte_data}, {24'd0, last_good});
    send_frame(8'h12, ^8'h12, 1'b1, K_VALID);
    idle(10);
    drain("drain_12");

    // Abort 0x81 with a reset in the middle of data bit 3.
    d = 8'h81;
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = d[3];
    repeat (HALF) @(posedge clk);
    #1;
    check("pre_reset_busy", {31'd0, rx_busy}, 1);
    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midframe_rst_busy", {31'd0, rx_busy}, 0);
    check("midframe_rst_data", {24'd0, byte_data}, 0);
    last_good = 8'h00;
    rst_n = 1'b1;
    idle(20);
    send_frame(8'h7E, ^8'h7E, 1'b1, K_VALID);
    idle(10);
    drain("drain_7e");

`ifdef MFP_UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, K_VALID);
    idle(10);
    send_frame(8'h07, 1'b0, 1'b1, K_PARITY);
    idle(10);
    drain("drain_parity");
`endif

    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, ^d, 1'b1, K_VALID);
    end
    idle(10);
    drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
